// File: rtl/updown_dir_ctrl.sv
// Mode/direction controller for a WIDTH-bit up/down counter.
// Debounced button cycles FREE_UP, FREE_DOWN, PINGPONG.
module updown_dir_ctrl #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Btn,
  input  logic [WIDTH-1:0] Q,
  output logic             M,
  output logic [1:0]       Mode,
  output logic             Btn_Pulse
);

  typedef enum logic [1:0] {
    FREE_UP   = 2'b00,
    FREE_DOWN = 2'b01,
    PINGPONG  = 2'b10,
    RSVD      = 2'b11
  } mode_e;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] Q_TURN_UP =
    WIDTH'((1 << WIDTH) - 2);
  localparam logic [WIDTH-1:0] Q_TURN_DN =
    WIDTH'(1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db_level;
  logic          r_db_dly;
  logic [CW-1:0] r_db_cnt;
  logic          r_pulse;
  logic          r_m;
  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic          w_m_nxt;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_db_level <= 1'b0;
      r_db_dly   <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_s1     <= Btn;
      r_s2     <= r_s1;
      r_db_dly <= r_db_level;
      if (r_s2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_s2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (r_pulse) begin
      unique case (r_mode)
        FREE_UP:   w_mode_nxt = FREE_DOWN;
        FREE_DOWN: w_mode_nxt = PINGPONG;
        PINGPONG:  w_mode_nxt = FREE_UP;
        RSVD:      w_mode_nxt = FREE_DOWN;
      endcase
    end
  end

  // Turn one step early: the counter moves on the same edge.
  always_comb begin
    w_m_nxt = 1'b1;
    unique case (w_mode_nxt)
      FREE_UP:   w_m_nxt = 1'b1;
      FREE_DOWN: w_m_nxt = 1'b0;
      PINGPONG: begin
        w_m_nxt = r_m;
        if (r_m && (Q == Q_TURN_UP))
          w_m_nxt = 1'b0;
        else if (!r_m && (Q == Q_TURN_DN))
          w_m_nxt = 1'b1;
      end
      RSVD:      w_m_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_mode  <= FREE_UP;
      r_m     <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= r_db_level & ~r_db_dly;
      r_mode  <= w_mode_nxt;
      r_m     <= w_m_nxt;
    end
  end

  assign M         = r_m;
  assign Mode      = r_mode;
  assign Btn_Pulse = r_pulse;

endmodule

// File: doc/updown_dir_ctrl.md
Name: updown_dir_ctrl

Overview:
- Direction/mode controller that sits directly upstream of the 3-bit synchronous up/down counter and drives its M input (1 = up, 0 = down).
- Debounces a raw push-button. Each press cycles the operating mode: FREE_UP, then FREE_DOWN, then PINGPONG, then back to FREE_UP.
- In PINGPONG it reads the counter's Q back and reverses M at the end values, so the count runs 0..MAX..0 with no wrap-around.
- Shares the counter's clock and active-low clear.

Parameters:
- WIDTH, 3, width of the counter value fed back on Q; MAX = 2^WIDTH-1.
- DEBOUNCE_CYCLES, 4, number of consecutive clock edges the synchronised button must hold a new level before it is accepted (≥2; use 4 in simulation).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Clr  input  1  asynchronous, active-low reset.
- Btn  input  1  raw asynchronous push-button, active-high.
- Q  input  WIDTH  current counter value, fed back from the counter.
- M  output  1  registered direction to the counter; 1 = up, 0 = down.
- Mode  output  2  registered mode: 00 FREE_UP, 01 FREE_DOWN, 10 PINGPONG.
- Btn_Pulse  output  1  registered one-cycle strobe for each accepted press.

Behaviour:
- Reset (Clr=0, asynchronous, no clock needed):
  - Mode=00, M=1, Btn_Pulse=0.
  - Synchroniser flops, debounced level and debounce counter all cleared to 0.
  - The counter clears to Q=0 on the same Clr.
- Synchroniser: two flops, s1<=Btn and s2<=s1. Only s2 is used downstream.
- Debounce:
  - The counter increments on each edge where s2 != db_level and clears on any edge where s2 == db_level.
  - db_level flips on the edge where s2 has differed for DEBOUNCE_CYCLES consecutive edges; the counter clears on that same edge.
  - Any bounce shorter than DEBOUNCE_CYCLES edges is ignored.
- Press latency: take edge 1 as the first edge that samples Btn=1 with Btn held high.
  - s2=1 after edge 2.
  - db_level=1 after edge 2+N, where N=DEBOUNCE_CYCLES.
  - Btn_Pulse=1 for exactly the cycle after edge 3+N.
  - Mode and M update at edge 4+N.
- Releases are debounced identically but produce no pulse. Holding the button produces exactly one pulse.
- Mode FSM, advancing at the edge that ends the Btn_Pulse cycle: 00 -> 01 -> 10 -> 00. Encoding 11 is unreachable; if present it is decoded as FREE_UP and the next transition goes to 01.
- M register, next value by mode:
  - FREE_UP: M=1.
  - FREE_DOWN: M=0.
  - PINGPONG, evaluated on every edge including the first edge in PINGPONG:
    - if M=1 and Q==MAX-1, M becomes 0;
    - if M=0 and Q==1, M becomes 1;
    - otherwise M holds.
- Turnaround timing in PINGPONG:
  - The counter steps on the same edge, so M is already reversed when Q reaches MAX or 0.
  - Sequence from reset: 0,1,…,7,6,…,1,0,1,…
- Entering PINGPONG:
  - M keeps its current value, subject to the rule above.
  - If Q==MAX and M=1 at entry, the counter wraps to 0 once and then ping-pongs normally. Same for Q==0 and M=0, which wraps to MAX. This is accepted behaviour.
- FREE modes: plain wrap-around counting (7->0 up, 0->7 down).
- Mid-operation Clr=0: everything returns to reset values immediately, and any press in progress is discarded.
- No combinational path from any input to any output.

Test Plan:
- Reset, then Btn=0 for 20 cycles -> Mode=00 and M=1 throughout. Q (counter in loop) goes 0,1,…,7,0.
- Btn pulses high for 3 cycles, then low (N=4) -> no Btn_Pulse and Mode stays 00. Btn held high for 10 cycles -> one Btn_Pulse in the cycle after edge 7; Mode=01 and M=0 after edge 8.
- From Mode=01, release the button and press again, held -> Mode=10. With the loop closed from Q=0, M=1: Q goes 0..7,6..0,1 with M=0 exactly when Q=7 and M=1 exactly when Q=0.
- Enter PINGPONG with Q=7 and M=1 -> Q goes 0,1,… once and then turns at 7 without wrapping again.
- Clr pulsed low mid-count (Mode=10, Q=5, debounce counter at 2) -> immediately Mode=00, M=1, Btn_Pulse=0 and Q=0, with no pulse after Clr is released.
- Btn held high for 50 cycles -> exactly one Btn_Pulse. Release plus 10 cycles low -> no pulse, and db_level=0 after N+2 edges.
